// File: rtl/ysyx_23060240_ifu_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package ysyx_23060240_ifu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060240_ifu.sv
// Instruction fetch unit: one fetch in flight, redirects squash stale responses.
module ysyx_23060240_ifu
  import ysyx_23060240_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_err_q, inst_err_d;
  logic [31:0] redir_pc;

  assign redir_pc = align_pc(redirect_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      inst_q     <= NOP_INST;
      inst_pc_q  <= 32'h0;
      inst_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_err_q <= inst_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_err_d = inst_err_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = redir_pc;
      end
      S_REQ: begin
        if (redirect_valid) pc_d = redir_pc;
        // The old pc is what the memory sampled, so its word must be squashed.
        if (req_ready) begin
          state_d = S_WAIT;
          kill_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
            if (redirect_valid) pc_d = redir_pc;
          end else begin
            inst_d     = rsp_data;
            inst_pc_d  = pc_q;
            inst_err_d = rsp_err;
            state_d    = S_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
          pc_d   = redir_pc;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_valid  = (state_q == S_REQ);
  assign inst_valid = (state_q == S_HOLD);
  assign req_addr   = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_err   = inst_err_q;

  // A response with nothing outstanding is a memory-side protocol bug.
  a_rsp_in_wait: assert property (@(posedge clk) disable iff (rst)
    rsp_valid |-> (state_q == S_WAIT));

endmodule

// File: tb/tb_ysyx_23060240_ifu.sv
// Directed bench for the fetch unit; inputs change and outputs are sampled 1ns after posedge.
module tb_ysyx_23060240_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        inst_valid, inst_ready, inst_err;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_vec = 0;
  int n_err = 0;

  ysyx_23060240_ifu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_err(inst_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_ready = 0; rsp_valid = 0; rsp_data = 0; rsp_err = 0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
  endtask

  // From REQ: handshake, then 1-cycle response; leaves FSM in HOLD.
  task automatic fetch(input logic [31:0] data, input logic err);
    req_ready = 1; tick(); req_ready = 0;
    rsp_valid = 1; rsp_data = data; rsp_err = err; tick();
    rsp_valid = 0; rsp_err = 0;
  endtask

  initial begin
    idle_in();
    rst = 1;
    tick(); tick();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_err", 32'(inst_err), 32'd0);
    chk("rst_addr", req_addr, 32'h8000_0000);
    rst = 0;
    tick();
    chk("t1_req_valid", 32'(req_valid), 32'd1);
    chk("t1_addr", req_addr, 32'h8000_0000);

    // 1: basic fetch
    req_ready = 1; tick(); req_ready = 0;
    chk("t1_wait_req", 32'(req_valid), 32'd0);
    rsp_valid = 1; rsp_data = 32'h0000_0297; tick(); rsp_valid = 0;
    chk("t1_inst_valid", 32'(inst_valid), 32'd1);
    chk("t1_inst", inst, 32'h0000_0297);
    chk("t1_inst_pc", inst_pc, 32'h8000_0000);
    chk("t1_inst_err", 32'(inst_err), 32'd0);

    // 2: decode stalls 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_inst_valid", 32'(inst_valid), 32'd1);
      chk("t2_req_valid", 32'(req_valid), 32'd0);
      chk("t2_inst", inst, 32'h0000_0297);
      chk("t2_inst_pc", inst_pc, 32'h8000_0000);
    end
    inst_ready = 1; tick(); inst_ready = 0;
    chk("t1_next_req", 32'(req_valid), 32'd1);
    chk("t1_next_addr", req_addr, 32'h8000_0004);
    chk("t1_next_ivalid", 32'(inst_valid), 32'd0);

    // 3: redirect in WAIT, response 3 cycles later is squashed
    req_ready = 1; tick(); req_ready = 0;
    redirect_valid = 1; redirect_pc = 32'h8000_0100; tick(); redirect_valid = 0;
    tick(); tick();
    chk("t3_wait_ivalid", 32'(inst_valid), 32'd0);
    rsp_valid = 1; rsp_data = 32'hDEAD_BEEF; tick(); rsp_valid = 0;
    chk("t3_dropped", 32'(inst_valid), 32'd0);
    chk("t3_req_valid", 32'(req_valid), 32'd1);
    chk("t3_addr", req_addr, 32'h8000_0100);

    // 4: redirect coincident with response, low bits forced to zero
    req_ready = 1; tick(); req_ready = 0;
    rsp_valid = 1; rsp_data = 32'hCAFE_F00D;
    redirect_valid = 1; redirect_pc = 32'h8000_0103; tick();
    rsp_valid = 0; redirect_valid = 0;
    chk("t4_dropped", 32'(inst_valid), 32'd0);
    chk("t4_req_valid", 32'(req_valid), 32'd1);
    chk("t4_addr", req_addr, 32'h8000_0100);
    fetch(32'h0010_0073, 1'b0);
    chk("t4_kill_clr", 32'(inst_valid), 32'd1);
    chk("t4_inst", inst, 32'h0010_0073);
    chk("t4_inst_pc", inst_pc, 32'h8000_0100);

    // 5: faulting fetch then clean fetch
    inst_ready = 1; tick(); inst_ready = 0;
    chk("t5_addr", req_addr, 32'h8000_0104);
    fetch(32'h0, 1'b1);
    chk("t5_ivalid", 32'(inst_valid), 32'd1);
    chk("t5_err", 32'(inst_err), 32'd1);
    chk("t5_inst", inst, 32'h0);
    chk("t5_inst_pc", inst_pc, 32'h8000_0104);
    inst_ready = 1; tick(); inst_ready = 0;
    chk("t5_next_addr", req_addr, 32'h8000_0108);
    fetch(32'h0000_0013, 1'b0);
    chk("t5_err_clr", 32'(inst_err), 32'd0);
    chk("t5_next_pc", inst_pc, 32'h8000_0108);

    // 6: redirect from HOLD without consume, wrap of pc+4, reset in WAIT
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect_valid = 0;
    chk("t6_hold_drop", 32'(inst_valid), 32'd0);
    chk("t6_redir_addr", req_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_006F, 1'b0);
    chk("t6_inst_pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1; tick(); inst_ready = 0;
    chk("t6_wrap_addr", req_addr, 32'h0);
    req_ready = 1; tick(); req_ready = 0;
    chk("t6_in_wait", 32'(req_valid), 32'd0);
    rst = 1; #1;
    chk("t6_rst_req", 32'(req_valid), 32'd0);
    chk("t6_rst_ivalid", 32'(inst_valid), 32'd0);
    chk("t6_rst_inst_pc", inst_pc, 32'h0);
    chk("t6_rst_inst", inst, 32'h0000_0013);
    tick(); rst = 0;
    tick();
    chk("t6_refetch_req", 32'(req_valid), 32'd1);
    chk("t6_refetch_addr", req_addr, 32'h8000_0000);

    // REQ-state redirects: without and with handshake
    redirect_valid = 1; redirect_pc = 32'h8000_0200; tick(); redirect_valid = 0;
    chk("r_noready_req", 32'(req_valid), 32'd1);
    chk("r_noready_addr", req_addr, 32'h8000_0200);
    redirect_valid = 1; redirect_pc = 32'h8000_0300; req_ready = 1; tick();
    redirect_valid = 0; req_ready = 0;
    chk("r_ready_wait", 32'(req_valid), 32'd0);
    rsp_valid = 1; rsp_data = 32'h1234_5678; tick(); rsp_valid = 0;
    chk("r_ready_drop", 32'(inst_valid), 32'd0);
    chk("r_ready_addr", req_addr, 32'h8000_0300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
